// File: rtl/shift_register_universal_burst.sv
// rtl/shift_register_universal_burst.sv - universal shift register with self-timed MSB-first burst serialiser
module shift_register_universal_burst #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       opr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sin_right,
    input  logic             sin_left,
    output logic [WIDTH-1:0] data_out,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_START = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_LAST  = CW'(1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    assign sout_msb = data_out[WIDTH-1];
    assign sout_lsb = data_out[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            count    <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    case (opr)
                        3'd0: data_out <= data_out;
                        3'd1: data_out <= data_in;
                        3'd2: data_out <= {data_out[WIDTH-2:0], sin_right};
                        3'd3: data_out <= {sin_left, data_out[WIDTH-1:1]};
                        3'd4: data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                        3'd5: data_out <= {data_out[0], data_out[WIDTH-1:1]};
                        3'd6: data_out <= '0;
                        3'd7: begin
                            data_out <= data_in;
                            count    <= COUNT_START;
                            state    <= BURST;
                            busy     <= 1'b1;
                        end
                        default: data_out <= data_out;
                    endcase
                end
                BURST: begin
                    // Only clear is honoured mid-burst; it aborts silently.
                    if (opr == 3'd6) begin
                        data_out <= '0;
                        count    <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        data_out <= {data_out[WIDTH-2:0], sin_right};
                        count    <= count - COUNT_LAST;
                        if (count == COUNT_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_universal_burst.sv
// tb/tb_shift_register_universal_burst.sv - scoreboard bench for shift_register_universal_burst
module tb_shift_register_universal_burst;

    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   opr = 3'd0;
    logic [W-1:0] data_in = '0;
    logic         sin_right = 1'b0;
    logic         sin_left = 1'b0;
    logic [W-1:0] data_out;
    logic         sout_msb;
    logic         sout_lsb;
    logic         busy;
    logic         done;

    shift_register_universal_burst #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .opr      (opr),
        .data_in  (data_in),
        .sin_right(sin_right),
        .sin_left (sin_left),
        .data_out (data_out),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] data;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: register value plus number of burst shifts still owed.
    int unsigned m_reg = 0;
    int unsigned m_rem = 0;
    logic        m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [2:0] o, input logic [W-1:0] d, input logic sr, input logic sl);
        m_done = 1'b0;
        if (m_rem == 0) begin
            case (o)
                3'd1: m_reg = d;
                3'd2: m_reg = ((m_reg * 2) + sr) & MASK;
                3'd3: m_reg = (m_reg / 2) + (sl ? (1 << (W - 1)) : 0);
                3'd4: m_reg = ((m_reg * 2) & MASK) + (m_reg / (1 << (W - 1)));
                3'd5: m_reg = (m_reg / 2) + ((m_reg % 2) << (W - 1));
                3'd6: m_reg = 0;
                3'd7: begin
                    m_reg = d;
                    m_rem = W - 1;
                end
                default: ;
            endcase
        end else if (o == 3'd6) begin
            m_reg = 0;
            m_rem = 0;
        end else begin
            m_reg = ((m_reg * 2) + sr) & MASK;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1'b1;
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [W-1:0] d, input logic sr, input logic sl);
        exp_t e;
        @(negedge clock);
        opr = o;
        data_in = d;
        sin_right = sr;
        sin_left = sl;
        model_step(o, d, sr, sl);
        e.data = W'(m_reg);
        e.busy = (m_rem != 0);
        e.done = m_done;
        q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a new register state, compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_data", 32'(data_out), 32'(e.data));
                check("sb_busy", 32'(busy), 32'(e.busy));
                check("sb_done", 32'(done), 32'(e.done));
                check("sb_msb", 32'(sout_msb), 32'(e.data[W-1]));
                check("sb_lsb", 32'(sout_lsb), 32'(e.data[0]));
            end
        end
    end

    initial begin
        logic [7:0] seq;

        #2;
        check("reset_data", 32'(data_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        step(3'd1, 8'hA5, 1'b0, 1'b0); after_edge(); check("load_a5", 32'(data_out), 32'hA5);
        step(3'd2, 8'h00, 1'b1, 1'b0); after_edge(); check("shl_4b", 32'(data_out), 32'h4B);
        step(3'd1, 8'hA5, 1'b0, 1'b0);
        step(3'd3, 8'h00, 1'b1, 1'b0); after_edge(); check("shr_52", 32'(data_out), 32'h52);
        step(3'd1, 8'hA5, 1'b0, 1'b0);
        step(3'd4, 8'h00, 1'b0, 1'b1); after_edge(); check("rol_4b", 32'(data_out), 32'h4B);
        step(3'd5, 8'h00, 1'b1, 1'b1); after_edge(); check("ror_a5", 32'(data_out), 32'hA5);
        step(3'd6, 8'hFF, 1'b1, 1'b1); after_edge(); check("clr_00", 32'(data_out), 32'h00);

        // Burst of 0xC3 with a held load that must be ignored.
        seq = 8'b11000011;
        step(3'd7, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            after_edge();
            check("c3_msb", 32'(sout_msb), 32'(seq[7-i]));
            check("c3_busy", 32'(busy), 32'(i < 7));
            check("c3_done", 32'(done), 32'(i == 7));
            if (i < 7) step(3'd1, 8'hFF, 1'b0, 1'b0);
        end
        check("c3_final", 32'(data_out), 32'h80);

        // Abort in the third busy cycle.
        step(3'd7, 8'hF0, 1'b1, 1'b0);
        step(3'd0, 8'h00, 1'b1, 1'b0);
        step(3'd0, 8'h00, 1'b1, 1'b0);
        step(3'd6, 8'h00, 1'b1, 1'b0);
        after_edge();
        check("abort_data", 32'(data_out), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        repeat (8) step(3'd0, 8'h00, 1'b0, 1'b0);

        // Back-to-back bursts: restart issued during the done cycle.
        step(3'd7, 8'h81, 1'b0, 1'b0);
        repeat (7) step(3'd0, 8'h00, 1'b0, 1'b0);
        after_edge();
        check("b2b_done", 32'(done), 32'h1);
        seq = 8'b00111100;
        step(3'd7, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            after_edge();
            check("3c_msb", 32'(sout_msb), 32'(seq[7-i]));
            step(3'd0, 8'h00, 1'b0, 1'b0);
        end

        // Asynchronous reset in the fourth busy cycle.
        step(3'd7, 8'hFF, 1'b1, 1'b0);
        repeat (3) step(3'd0, 8'h00, 1'b1, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_data", 32'(data_out), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        m_reg = 0;
        m_rem = 0;
        m_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(3'd1, 8'h5A, 1'b0, 1'b0); after_edge(); check("post_rst_load", 32'(data_out), 32'h5A);

        // Randomized traffic against the model; clears kept rarer so bursts can complete.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            if (o == 3'd6 && $urandom_range(0, 3) != 0) o = 3'd0;
            step(o, W'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clock);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
